// File: rtl/hexdisp_pkg.sv
// Shared types and constants for the hex text-line renderer and its buffer.
package hexdisp_pkg;

    localparam logic [7:0] CHAR_SPACE = 8'h10;
    localparam int         GLYPH_W    = 8;
    localparam int         GLYPH_H    = 16;
    localparam int         MAX_CHARS  = 64;

    typedef logic [3:0] nibble_t;
    typedef logic [5:0] char_idx_t;

    typedef enum logic {
        BUF_IDLE,
        BUF_PENDING
    } buf_state_t;

    // char_mem code for one character cell: a hex digit, or the space glyph when empty
    function automatic logic [7:0] glyphCode(input logic valid, input nibble_t nib);
        return valid ? {4'h0, nib} : CHAR_SPACE;
    endfunction

endpackage

// File: rtl/hex_line_buf.sv
// Shadow/display character buffers for one hex text line.
// The writer edits the shadow copy freely; a commit is copied into the
// display copy only on a frame_start, so a frame never shows a half-update.
module hex_line_buf
    import hexdisp_pkg::*;
#(
    parameter int NCHARS = 64
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_wr_en,
    input  char_idx_t i_wr_addr,
    input  nibble_t   i_wr_nibble,
    input  logic      i_clr,
    input  logic      i_commit,
    input  logic      i_frame_start,
    input  char_idx_t i_rd_idx,
    output nibble_t   o_rd_nibble,
    output logic      o_rd_valid,
    output logic      o_busy
);

    buf_state_t r_state;
    buf_state_t w_nextState;

    logic [MAX_CHARS-1:0][3:0] r_shadowNib;
    logic [MAX_CHARS-1:0][3:0] r_dispNib;
    logic [MAX_CHARS-1:0]      r_shadowValid;
    logic [MAX_CHARS-1:0]      r_dispValid;

    logic w_wrOk;
    logic w_doCopy;

    assign w_wrOk   = i_wr_en && (int'(i_wr_addr) < NCHARS);
    assign w_doCopy = i_frame_start && (r_state == BUF_PENDING);

    // Commit state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= BUF_IDLE;
        else        r_state <= w_nextState;
    end

    // A commit arriving on the copy cycle keeps the request alive for one more frame
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            BUF_IDLE:    if (i_commit) w_nextState = BUF_PENDING;
            BUF_PENDING: if (i_frame_start && !i_commit) w_nextState = BUF_IDLE;
            default:     w_nextState = BUF_IDLE;
        endcase
    end

    // Valid bits: clear beats write, and the copy sees the pre-write shadow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadowValid <= '0;
            r_dispValid   <= '0;
        end else begin
            if (i_clr)       r_shadowValid           <= '0;
            else if (w_wrOk) r_shadowValid[i_wr_addr] <= 1'b1;
            if (w_doCopy)    r_dispValid             <= r_shadowValid;
        end
    end

    // Nibble storage needs no reset since every entry is gated by its valid bit
    always_ff @(posedge clk) begin
        if (!i_clr && w_wrOk) r_shadowNib[i_wr_addr] <= i_wr_nibble;
        if (w_doCopy)         r_dispNib              <= r_shadowNib;
    end

    assign o_rd_nibble = r_dispNib[i_rd_idx];
    assign o_rd_valid  = r_dispValid[i_rd_idx];
    assign o_busy      = (r_state == BUF_PENDING);

endmodule

// File: rtl/hex_line_renderer.sv
// Draws one line of hex digits through an external char_mem glyph ROM.
// Stage 0 picks the character code and glyph row for the current pixel,
// char_mem answers combinationally, stage 1 picks the bit: 2-cycle latency.
module hex_line_renderer
    import hexdisp_pkg::*;
#(
    parameter int NCHARS = 64,
    parameter int X0     = 0,
    parameter int Y0     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic       video_on,
    input  logic       frame_start,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [3:0] wr_nibble,
    input  logic       clr,
    input  logic       commit,
    output logic       busy,
    output logic [7:0] glyph_data,
    output logic [3:0] glyph_row,
    input  logic [7:0] glyph_bits,
    output logic       pixel_on,
    output logic       pixel_valid
);

    logic [10:0] w_dxFull;
    logic [10:0] w_dyFull;
    logic [9:0]  w_dx;
    logic [9:0]  w_dy;
    logic        w_inReg;
    nibble_t     w_rdNibble;
    logic        w_rdValid;

    logic        r_inReg;
    logic [2:0]  r_bsel;
    logic        r_videoOn;

    // The extra top bit of the 11-bit difference flags a pixel left of / above the line
    assign w_dxFull = {1'b0, h_cnt} - 11'(X0);
    assign w_dyFull = {1'b0, v_cnt} - 11'(Y0);
    assign w_dx     = w_dxFull[9:0];
    assign w_dy     = w_dyFull[9:0];
    assign w_inReg  = video_on && !w_dxFull[10] && (w_dx < 10'(GLYPH_W * NCHARS))
                      && !w_dyFull[10] && (w_dy < 10'(GLYPH_H));

    hex_line_buf #(
        .NCHARS(NCHARS)
    ) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr_en      (wr_en),
        .i_wr_addr    (wr_addr),
        .i_wr_nibble  (wr_nibble),
        .i_clr        (clr),
        .i_commit     (commit),
        .i_frame_start(frame_start),
        .i_rd_idx     (w_dx[8:3]),
        .o_rd_nibble  (w_rdNibble),
        .o_rd_valid   (w_rdValid),
        .o_busy       (busy)
    );

    // Stage 0: register the char_mem address plus the bit select it will need
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            glyph_data <= CHAR_SPACE;
            glyph_row  <= '0;
            r_inReg    <= 1'b0;
            r_bsel     <= '0;
            r_videoOn  <= 1'b0;
        end else begin
            glyph_data <= glyphCode(w_inReg && w_rdValid, w_rdNibble);
            glyph_row  <= w_inReg ? w_dy[3:0] : 4'h0;
            r_inReg    <= w_inReg;
            r_bsel     <= w_dx[2:0];
            r_videoOn  <= video_on;
        end
    end

    // Stage 1: leftmost pixel of a glyph is its MSB
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_on    <= 1'b0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_on    <= r_inReg && glyph_bits[3'd7 - r_bsel];
            pixel_valid <= r_videoOn;
        end
    end

endmodule

// File: tb/tb_hex_line_renderer.sv
// Scoreboard bench for hex_line_renderer with a small line (8 chars at 16,32).
module tb_hex_line_renderer;

    localparam int NCH = 8;
    localparam int X0  = 16;
    localparam int Y0  = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       video_on;
    logic       frame_start;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [3:0] wr_nibble;
    logic       clr;
    logic       commit;
    logic       busy;
    logic [7:0] glyph_data;
    logic [3:0] glyph_row;
    logic [7:0] glyph_bits;
    logic       pixel_on;
    logic       pixel_valid;

    typedef struct {
        int         due;
        int         kind;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    hex_line_renderer #(
        .NCHARS(NCH),
        .X0    (X0),
        .Y0    (Y0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .video_on   (video_on),
        .frame_start(frame_start),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_nibble  (wr_nibble),
        .clr        (clr),
        .commit     (commit),
        .busy       (busy),
        .glyph_data (glyph_data),
        .glyph_row  (glyph_row),
        .glyph_bits (glyph_bits),
        .pixel_on   (pixel_on),
        .pixel_valid(pixel_valid)
    );

    // Stand-in char_mem: every digit row is 8'b01111000, space is blank
    assign glyph_bits = (glyph_data == 8'h10) ? 8'h00 : 8'h78;

    // Pixel clock
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expectations
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expectVal(input int delay, input int kind, input logic [7:0] val, input string name);
        exp_t e;
        e.due  = cyc + delay;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [7:0] act;
        case (e.kind)
            0:       act = glyph_data;
            1:       act = {4'h0, glyph_row};
            2:       act = {7'b0, pixel_on};
            3:       act = {7'b0, pixel_valid};
            default: act = {7'b0, busy};
        endcase
        checks++;
        if (act !== e.val) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", e.name, act, e.val, cyc);
        end
    endtask

    // Monitor: compare every expectation that has come due, on the falling edge
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            checkOutput(sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        wr_en       = 1'b0;
        clr         = 1'b0;
        commit      = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic applyStimulus(input int h, input int v, input logic vid,
                                 input logic [7:0] eData, input logic [3:0] eRow,
                                 input logic eOn, input logic eValid, input string name);
        h_cnt    = 10'(h);
        v_cnt    = 10'(v);
        video_on = vid;
        expectVal(1, 0, eData, {name, ".data"});
        expectVal(1, 1, {4'h0, eRow}, {name, ".row"});
        expectVal(2, 2, {7'b0, eOn}, {name, ".on"});
        expectVal(2, 3, {7'b0, eValid}, {name, ".valid"});
        tick();
    endtask

    task automatic writeNib(input int a, input logic [3:0] n);
        wr_en     = 1'b1;
        wr_addr   = 6'(a);
        wr_nibble = n;
        tick();
    endtask

    task automatic commitPulse(input logic eBusy, input string name);
        commit = 1'b1;
        expectVal(1, 4, {7'b0, eBusy}, name);
        tick();
    endtask

    task automatic framePulse(input logic eBusy, input string name);
        frame_start = 1'b1;
        expectVal(1, 4, {7'b0, eBusy}, name);
        tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        h_cnt       = '0;
        v_cnt       = '0;
        video_on    = 1'b0;
        frame_start = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_nibble   = '0;
        clr         = 1'b0;
        commit      = 1'b0;

        // Reset values while an in-region pixel is presented
        expectVal(1, 4, 8'h00, "reset.busy");
        applyStimulus(X0 + 1, Y0 + 5, 1'b1, 8'h10, 4'h0, 1'b0, 1'b0, "reset");
        tick();
        tick();
        rst_n = 1'b1;

        // 1: empty display sweeps as spaces with no foreground
        framePulse(1'b0, "t1.busy");
        for (int h = X0 - 2; h <= X0 + 8 * NCH + 1; h++) begin
            if (h >= X0 && h < X0 + 8 * NCH)
                applyStimulus(h, Y0 + 3, 1'b1, 8'h10, 4'h3, 1'b0, 1'b1, "t1.in");
            else
                applyStimulus(h, Y0 + 3, 1'b1, 8'h10, 4'h0, 1'b0, 1'b1, "t1.out");
        end

        // 2: one digit committed and drawn
        writeNib(0, 4'hA);
        commitPulse(1'b1, "t2.busySet");
        framePulse(1'b0, "t2.busyClr");
        applyStimulus(X0 + 1, Y0 + 5,  1'b1, 8'h0A, 4'h5, 1'b1, 1'b1, "t2.h1");
        applyStimulus(X0 + 0, Y0 + 5,  1'b1, 8'h0A, 4'h5, 1'b0, 1'b1, "t2.h0");
        applyStimulus(X0 + 4, Y0 + 5,  1'b1, 8'h0A, 4'h5, 1'b1, 1'b1, "t2.h4");
        applyStimulus(X0 + 5, Y0 + 5,  1'b1, 8'h0A, 4'h5, 1'b0, 1'b1, "t2.h5");
        applyStimulus(X0 + 8, Y0 + 5,  1'b1, 8'h10, 4'h5, 1'b0, 1'b1, "t2.col1");
        applyStimulus(X0 + 1, Y0 + 15, 1'b1, 8'h0A, 4'hF, 1'b1, 1'b1, "t2.lastRow");
        applyStimulus(X0 + 1, Y0 + 16, 1'b1, 8'h10, 4'h0, 1'b0, 1'b1, "t2.below");
        applyStimulus(X0 + 1, Y0 - 1,  1'b1, 8'h10, 4'h0, 1'b0, 1'b1, "t2.above");
        applyStimulus(X0 - 1, Y0 + 5,  1'b1, 8'h10, 4'h0, 1'b0, 1'b1, "t2.left");
        applyStimulus(X0 + 1, Y0 + 5,  1'b0, 8'h10, 4'h0, 1'b0, 1'b0, "t2.blank");

        // 3: writes stay hidden until commit plus frame_start
        writeNib(1, 4'h3);
        framePulse(1'b0, "t3.noCommitBusy");
        applyStimulus(X0 + 8, Y0, 1'b1, 8'h10, 4'h0, 1'b0, 1'b1, "t3.noCommit");
        commitPulse(1'b1, "t3.busySet");
        applyStimulus(X0 + 8, Y0, 1'b1, 8'h10, 4'h0, 1'b0, 1'b1, "t3.pending");
        framePulse(1'b0, "t3.busyClr");
        applyStimulus(X0 + 8, Y0,     1'b1, 8'h03, 4'h0, 1'b0, 1'b1, "t3.shown");
        applyStimulus(X0 + 9, Y0 + 7, 1'b1, 8'h03, 4'h7, 1'b1, 1'b1, "t3.shownH9");

        // 3b: commit on the frame_start cycle while idle only arms the copy
        writeNib(2, 4'h9);
        commit      = 1'b1;
        frame_start = 1'b1;
        expectVal(1, 4, 8'h01, "t3b.busy");
        tick();
        applyStimulus(X0 + 16, Y0 + 1, 1'b1, 8'h10, 4'h1, 1'b0, 1'b1, "t3b.notYet");
        framePulse(1'b0, "t3b.busyClr");
        applyStimulus(X0 + 18, Y0 + 1, 1'b1, 8'h09, 4'h1, 1'b1, 1'b1, "t3b.shown");

        // 3c: commit on the copy cycle copies now and stays armed
        writeNib(2, 4'hB);
        commitPulse(1'b1, "t3c.busySet");
        commit      = 1'b1;
        frame_start = 1'b1;
        expectVal(1, 4, 8'h01, "t3c.busyHeld");
        tick();
        applyStimulus(X0 + 16, Y0 + 1, 1'b1, 8'h0B, 4'h1, 1'b0, 1'b1, "t3c.first");
        writeNib(2, 4'hC);
        framePulse(1'b0, "t3c.busyClr");
        applyStimulus(X0 + 16, Y0 + 1, 1'b1, 8'h0C, 4'h1, 1'b0, 1'b1, "t3c.second");

        // 4: a write on the copy cycle lands in shadow only
        writeNib(3, 4'h5);
        commitPulse(1'b1, "t4.busySet");
        frame_start = 1'b1;
        wr_en       = 1'b1;
        wr_addr     = 6'd3;
        wr_nibble   = 4'h7;
        expectVal(1, 4, 8'h00, "t4.busyClr");
        tick();
        applyStimulus(X0 + 24, Y0 + 2, 1'b1, 8'h05, 4'h2, 1'b0, 1'b1, "t4.old");
        commitPulse(1'b1, "t4.busySet2");
        framePulse(1'b0, "t4.busyClr2");
        applyStimulus(X0 + 25, Y0 + 2, 1'b1, 8'h07, 4'h2, 1'b1, 1'b1, "t4.new");

        // 5: out-of-range address, right edge, clear beats write
        writeNib(NCH, 4'h1);
        applyStimulus(X0 + 8 * NCH, Y0 + 2,     1'b1, 8'h10, 4'h0, 1'b0, 1'b1, "t5.rightEdge");
        applyStimulus(X0 + 8 * NCH - 1, Y0 + 2, 1'b1, 8'h10, 4'h2, 1'b0, 1'b1, "t5.lastCol");
        clr       = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 6'd4;
        wr_nibble = 4'h6;
        tick();
        commitPulse(1'b1, "t5.busySet");
        framePulse(1'b0, "t5.busyClr");
        applyStimulus(X0 + 0,  Y0 + 5, 1'b1, 8'h10, 4'h5, 1'b0, 1'b1, "t5.clr0");
        applyStimulus(X0 + 32, Y0 + 5, 1'b1, 8'h10, 4'h5, 1'b0, 1'b1, "t5.clrWins");
        applyStimulus(X0 + 24, Y0 + 2, 1'b1, 8'h10, 4'h2, 1'b0, 1'b1, "t5.clr3");
        writeNib(4, 4'h6);
        commitPulse(1'b1, "t5.busySet2");
        framePulse(1'b0, "t5.busyClr2");
        applyStimulus(X0 + 33, Y0 + 4, 1'b1, 8'h06, 4'h4, 1'b1, 1'b1, "t5.rewrite");

        // 6: reset pulse in the middle of the line
        commitPulse(1'b1, "t6.busySet");
        applyStimulus(X0 + 34, Y0 + 4, 1'b1, 8'h06, 4'h4, 1'b1, 1'b1, "t6.before");
        h_cnt = 10'(X0 + 35);
        tick();
        rst_n = 1'b0;
        expectVal(1, 4, 8'h00, "t6.busyRst");
        applyStimulus(X0 + 35, Y0 + 4, 1'b1, 8'h10, 4'h0, 1'b0, 1'b0, "t6.rst");
        rst_n = 1'b1;
        applyStimulus(X0 + 36, Y0 + 4, 1'b1, 8'h10, 4'h4, 1'b0, 1'b1, "t6.after");
        framePulse(1'b0, "t6.busyIdle");
        applyStimulus(X0 + 33, Y0 + 4, 1'b1, 8'h10, 4'h4, 1'b0, 1'b1, "t6.blank");

        tick();
        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
